// File: rtl/core_pkg.sv
// Shared types for the RV32 pipeline: ALU opcodes, forwarding selects
// and the E-stage control bundle.
package core_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_PASSB = 3'b101,
        ALU_SLL   = 3'b110,
        ALU_SRL   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        alu_op_e    alu_ctrl;
    } ctrl_e_t;

    // All-zero control is a harmless add with no side effects.
    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: register file value, W-stage result or
// M-stage ALU result. The reserved select falls back to the register file.
module fwd_mux
    import core_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] rf,
    input  logic [W-1:0] w,
    input  logic [W-1:0] m,
    output logic [W-1:0] y
);

    always_comb begin
        y = rf;
        case (sel)
            FWD_W:   y = w;
            FWD_M:   y = m;
            default: y = rf;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/Execute pipeline register with stall, flush and the
// E-stage operand forwarding / immediate-select muxes.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic                  ALUSrcD,
    input  logic [1:0]            ResultSrcD,
    input  logic [2:0]            ALUctrlD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] ResultW,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic [1:0]            ResultSrcE,
    output logic [2:0]            ALUctrlE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic                  ValidE,
    output logic [DATA_WIDTH-1:0] SrcAE,
    output logic [DATA_WIDTH-1:0] SrcBE,
    output logic [DATA_WIDTH-1:0] WriteDataE
);

    ctrl_e_t               ctrl_q, ctrl_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    // Priority: reset, then flush (beats stall), then stall, then load.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        if (rst || FlushE) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            pc_d    = '0;
            pc4_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
        end else if (!StallE) begin
            ctrl_d.reg_write  = RegWriteD;
            ctrl_d.mem_write  = MemWriteD;
            ctrl_d.jump       = JumpD;
            ctrl_d.branch     = BranchD;
            ctrl_d.alu_src    = ALUSrcD;
            ctrl_d.result_src = ResultSrcD;
            ctrl_d.alu_ctrl   = alu_op_e'(ALUctrlD);
            valid_d = 1'b1;
            rd1_d   = RD1D;
            rd2_d   = RD2D;
            imm_d   = ImmExtD;
            pc_d    = PCD;
            pc4_d   = PCPlus4D;
            rs1_d   = Rs1D;
            rs2_d   = Rs2D;
            rd_d    = RdD;
        end
    end

    always_ff @(posedge clk) begin
        ctrl_q  <= ctrl_d;
        valid_q <= valid_d;
        rd1_q   <= rd1_d;
        rd2_q   <= rd2_d;
        imm_q   <= imm_d;
        pc_q    <= pc_d;
        pc4_q   <= pc4_d;
        rs1_q   <= rs1_d;
        rs2_q   <= rs2_d;
        rd_q    <= rd_d;
    end

    fwd_mux #(.W(DATA_WIDTH)) u_fwd_a (
        .sel (ForwardAE),
        .rf  (rd1_q),
        .w   (ResultW),
        .m   (ALUResultM),
        .y   (SrcAE)
    );

    fwd_mux #(.W(DATA_WIDTH)) u_fwd_b (
        .sel (ForwardBE),
        .rf  (rd2_q),
        .w   (ResultW),
        .m   (ALUResultM),
        .y   (WriteDataE)
    );

    assign SrcBE      = ctrl_q.alu_src ? imm_q : WriteDataE;

    assign RegWriteE  = ctrl_q.reg_write;
    assign MemWriteE  = ctrl_q.mem_write;
    assign JumpE      = ctrl_q.jump;
    assign BranchE    = ctrl_q.branch;
    assign ResultSrcE = ctrl_q.result_src;
    assign ALUctrlE   = ctrl_q.alu_ctrl;
    assign ValidE     = valid_q;
    assign PCE        = pc_q;
    assign PCPlus4E   = pc4_q;
    assign ImmExtE    = imm_q;
    assign Rs1E       = rs1_q;
    assign Rs2E       = rs2_q;
    assign RdE        = rd_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-Execute pipeline stage of the pipelined RV32 core. Registers every decoded control and data field on the D/E boundary, supports stall (hold) and flush (bubble insertion), and drives the ALU operands for the current Execute cycle through the forwarding and immediate-select muxes. Output `SrcAE`/`SrcBE`/`ALUctrlE` feed the ALU directly; all other `*E` outputs travel on to the E/M register.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath width
- `REG_ADDR_W`, 5, register index width

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `StallE`  in  1  hold all registered fields this cycle
- `FlushE`  in  1  load a bubble this cycle
- `RegWriteD`, `MemWriteD`, `JumpD`, `BranchD`, `ALUSrcD`  in  1 each  decoded control
- `ResultSrcD`  in  2  writeback select
- `ALUctrlD`  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 110 sll, 111 srl, 101 pass-B)
- `RD1D`, `RD2D`, `ImmExtD`, `PCD`, `PCPlus4D`  in  DATA_WIDTH each  decoded data
- `Rs1D`, `Rs2D`, `RdD`  in  REG_ADDR_W each  register indices
- `ForwardAE`, `ForwardBE`  in  2 each  forwarding selects from hazard unit (combinational, current E cycle)
- `ALUResultM`, `ResultW`  in  DATA_WIDTH each  forwarding sources
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ResultSrcE`, `ALUctrlE`  out  registered control
- `PCE`, `PCPlus4E`, `ImmExtE`  out  DATA_WIDTH  registered data
- `Rs1E`, `Rs2E`, `RdE`  out  REG_ADDR_W  registered indices (to hazard unit)
- `ValidE`  out  1  1 = real instruction, 0 = bubble
- `SrcAE`, `SrcBE`, `WriteDataE`  out  DATA_WIDTH  combinational ALU operands and store data

## Operation
- Per-edge priority: `rst` > `FlushE` > `StallE` > load.
- Load: all `*D` fields copied into `*E` registers; `ValidE` <= 1.
- Stall: every register holds; forwarding muxes still evaluate on live `ALUResultM`/`ResultW`.
- Flush: `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ValidE`, `ResultSrcE`, `ALUctrlE`, `Rs1E`, `Rs2E`, `RdE` <= 0; data registers (`RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E`) also cleared to 0. A bubble is therefore `add x0 = 0 + 0`, no write, no store, no branch.
- Flush with stall asserted in the same cycle: flush wins.
- Forward mux A (`ForwardAE`): 00 `RD1E`, 01 `ResultW`, 10 `ALUResultM`, 11 `RD1E` (reserved, treated as 00). Same encoding for B on `RD2E` producing `WriteDataE`.
- `SrcAE` = forward A result; `WriteDataE` = forward B result; `SrcBE` = `ImmExtE` when `ALUSrcE` = 1 else `WriteDataE`.
- `Rs1E`/`Rs2E` of 0 are passed unmodified; suppressing x0 forwarding is the hazard unit's job.

## Timing
- Reset: every registered output 0, `ValidE` 0; `SrcAE`/`SrcBE`/`WriteDataE` then follow the mux selects on zeroed registers.
- Latency: D field visible on `*E` one cycle after the edge it is loaded on; operand muxes zero-latency.
- A stall of N cycles holds `*E` for exactly N edges; the instruction resumes with no duplication or loss.
- `rst` asserted mid-stall or mid-flush: state is zero on the next edge, regardless of other inputs.

## Structure
- Shared `core_pkg`: `alu_op_e` enum (the eight `ALUctrl` encodings), `fwd_sel_e` enum (`FWD_RF`=00, `FWD_W`=01, `FWD_M`=10), and a `ctrl_e_t` packed struct bundling the control fields so flush/reset clear it as one assignment.
- One sub-module `fwd_mux` (2-bit select, three DATA_WIDTH sources), instantiated twice for A and B.

## Test plan
- Reset: assert `rst` with non-zero D inputs -> after edge all `*E`, `ValidE` = 0; `SrcAE` = `SrcBE` = 0 with selects 00.
- Plain load: `RD1D`=5, `RD2D`=7, `ALUctrlD`=001, `ALUSrcD`=0 -> next cycle `SrcAE`=5, `SrcBE`=7, `ALUctrlE`=001, `ValidE`=1.
- Immediate path: `ALUSrcD`=1, `ImmExtD`=0xFFFF_FFF0, `RD2D`=3 -> `SrcBE`=0xFFFF_FFF0, `WriteDataE`=3.
- Forwarding: `ForwardAE`=10, `ALUResultM`=0x1234, `ForwardBE`=01, `ResultW`=0xABCD -> `SrcAE`=0x1234, `SrcBE`=`WriteDataE`=0xABCD same cycle.
- Stall then flush: load instr with `RdE`=9, hold `StallE` 2 cycles while D changes -> `RdE` stays 9; then `FlushE`=1 and `StallE`=1 together -> next cycle `RegWriteE`=0, `RdE`=0, `ValidE`=0.
